// File: rtl/mult_pipe_pkg.sv
// Shared types for the pipelined RV32M multiplier.
// Function encoding and operand-signedness helpers.
package mult_pipe_pkg;

  typedef enum logic [1:0] {
    M_MUL    = 2'd0,
    M_MULH   = 2'd1,
    M_MULHSU = 2'd2,
    M_MULHU  = 2'd3
  } mult_func_t;

  localparam int XLEN_DEF       = 32;
  localparam int NUM_STAGES_DEF = 4;
  localparam int TAG_W_DEF      = 6;
  localparam int BMASK_W_DEF    = 4;

  function automatic logic rs1_signed(mult_func_t f);
    return f != M_MULHU;
  endfunction

  function automatic logic rs2_signed(mult_func_t f);
    return (f == M_MUL) || (f == M_MULH);
  endfunction

endpackage

// File: rtl/mult_stage.sv
// One multiplier pipeline stage: adds one rs2 chunk partial product
// and registers the stage packet with hold/squash/resolve.
import mult_pipe_pkg::*;

module mult_stage #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 6,
  parameter int BMASK_W    = 4,
  parameter int K          = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               advance,
  input  logic               squash_valid,
  input  logic [BMASK_W-1:0] squash_mask,
  input  logic               resolve_valid,
  input  logic [BMASK_W-1:0] resolve_mask,
  input  logic               prev_valid,
  input  mult_func_t         prev_func,
  input  logic [TAG_W-1:0]   prev_tag,
  input  logic [BMASK_W-1:0] prev_bmask,
  input  logic [2*XLEN-1:0]  prev_sum,
  input  logic [2*XLEN-1:0]  prev_rs1,
  input  logic [XLEN-1:0]    prev_rs2,
  output logic               cur_valid,
  output mult_func_t         cur_func,
  output logic [TAG_W-1:0]   cur_tag,
  output logic [BMASK_W-1:0] cur_bmask,
  output logic [2*XLEN-1:0]  cur_sum,
  output logic [2*XLEN-1:0]  cur_rs1,
  output logic [XLEN-1:0]    cur_rs2
);

  localparam int C   = XLEN / NUM_STAGES;
  localparam int SH  = K * C;
  localparam bit TOP = (K == NUM_STAGES - 1);

  typedef struct packed {
    logic               valid;
    mult_func_t         func;
    logic [TAG_W-1:0]   tag;
    logic [BMASK_W-1:0] bmask;
    logic [2*XLEN-1:0]  sum;
    logic [2*XLEN-1:0]  rs1;
    logic [XLEN-1:0]    rs2;
  } stage_pkt_t;

  stage_pkt_t q;

  logic [2*XLEN-1:0]  chunk;
  logic [2*XLEN-1:0]  pp;
  logic [BMASK_W-1:0] clr;
  logic               kill_prev;
  logic               kill_cur;

  always_comb begin
    chunk = '0;
    chunk[C-1:0] = prev_rs2[C-1:0];
    pp = (prev_rs1 * chunk) << SH;
    // signed rs2: the top chunk's msb weighs -2^(XLEN-1)
    if (TOP && rs2_signed(prev_func) && prev_rs2[C-1])
      pp = pp - (prev_rs1 << (SH + C));
    clr = resolve_valid ? resolve_mask : '0;
    kill_prev = squash_valid && |(prev_bmask & squash_mask);
    kill_cur  = squash_valid && |(q.bmask & squash_mask);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (advance) begin
      q.valid <= prev_valid && !kill_prev;
      q.func  <= prev_func;
      q.tag   <= prev_tag;
      q.bmask <= prev_bmask & ~clr;
      q.sum   <= prev_sum + pp;
      q.rs1   <= prev_rs1;
      q.rs2   <= prev_rs2 >> C;
    end else begin
      q.valid <= q.valid && !kill_cur;
      q.bmask <= q.bmask & ~clr;
    end
  end

  assign cur_valid = q.valid;
  assign cur_func  = q.func;
  assign cur_tag   = q.tag;
  assign cur_bmask = q.bmask;
  assign cur_sum   = q.sum;
  assign cur_rs1   = q.rs1;
  assign cur_rs2   = q.rs2;

endmodule

// File: rtl/mult_pipe.sv
// Fully pipelined RV32M multiplier FU with back-pressure and
// branch-mask squash/resolve.
import mult_pipe_pkg::*;

module mult_pipe #(
  parameter int XLEN       = XLEN_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int BMASK_W    = BMASK_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  mult_func_t         in_func,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [BMASK_W-1:0] in_bmask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               squash_valid,
  input  logic [BMASK_W-1:0] squash_mask,
  input  logic               resolve_valid,
  input  logic [BMASK_W-1:0] resolve_mask
);

  localparam int N = NUM_STAGES;

  logic               v_a   [N+1];
  mult_func_t         f_a   [N+1];
  logic [TAG_W-1:0]   tag_a [N+1];
  logic [BMASK_W-1:0] bm_a  [N+1];
  logic [2*XLEN-1:0]  sum_a [N+1];
  logic [2*XLEN-1:0]  rs1_a [N+1];
  logic [XLEN-1:0]    rs2_a [N+1];

  logic               advance;
  logic               out_vld_q;
  logic [BMASK_W-1:0] out_bm_q;
  logic [BMASK_W-1:0] clr;
  logic               kill_out;
  logic               kill_last;
  logic [XLEN-1:0]    res_sel;
  logic               unused;

  assign advance  = !out_vld_q || out_ready;
  assign in_ready = advance;

  assign v_a[0]   = in_valid;
  assign f_a[0]   = in_func;
  assign tag_a[0] = in_tag;
  assign bm_a[0]  = in_bmask;
  assign sum_a[0] = '0;
  assign rs2_a[0] = in_rs2;
  assign rs1_a[0] = rs1_signed(in_func)
                  ? {{XLEN{in_rs1[XLEN-1]}}, in_rs1}
                  : {{XLEN{1'b0}}, in_rs1};

  for (genvar g = 0; g < N; g++) begin : g_stage
    mult_stage #(
      .XLEN       (XLEN),
      .NUM_STAGES (NUM_STAGES),
      .TAG_W      (TAG_W),
      .BMASK_W    (BMASK_W),
      .K          (g)
    ) u_stage (
      .clock         (clock),
      .reset         (reset),
      .advance       (advance),
      .squash_valid  (squash_valid),
      .squash_mask   (squash_mask),
      .resolve_valid (resolve_valid),
      .resolve_mask  (resolve_mask),
      .prev_valid    (v_a[g]),
      .prev_func     (f_a[g]),
      .prev_tag      (tag_a[g]),
      .prev_bmask    (bm_a[g]),
      .prev_sum      (sum_a[g]),
      .prev_rs1      (rs1_a[g]),
      .prev_rs2      (rs2_a[g]),
      .cur_valid     (v_a[g+1]),
      .cur_func      (f_a[g+1]),
      .cur_tag       (tag_a[g+1]),
      .cur_bmask     (bm_a[g+1]),
      .cur_sum       (sum_a[g+1]),
      .cur_rs1       (rs1_a[g+1]),
      .cur_rs2       (rs2_a[g+1])
    );
  end

  assign unused = ^{rs1_a[N], rs2_a[N]};

  always_comb begin
    res_sel   = '0;
    clr       = resolve_valid ? resolve_mask : '0;
    kill_out  = squash_valid && |(out_bm_q & squash_mask);
    kill_last = squash_valid && |(bm_a[N] & squash_mask);
    case (f_a[N])
      M_MUL:    res_sel = sum_a[N][XLEN-1:0];
      M_MULH,
      M_MULHSU,
      M_MULHU:  res_sel = sum_a[N][2*XLEN-1:XLEN];
      default:  res_sel = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_vld_q  <= 1'b0;
      out_bm_q   <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (advance) begin
      out_vld_q  <= v_a[N] && !kill_last;
      out_bm_q   <= bm_a[N] & ~clr;
      out_result <= res_sel;
      out_tag    <= tag_a[N];
    end else begin
      out_vld_q  <= out_vld_q && !kill_out;
      out_bm_q   <= out_bm_q & ~clr;
    end
  end

  // a squashed result must never be handshaken
  assign out_valid = out_vld_q && !kill_out;

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe: latency, func sweep, stalls,
// squash/resolve and mid-flight reset.
import mult_pipe_pkg::*;

module tb_mult_pipe;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  mult_func_t  in_func;
  logic [5:0]  in_tag;
  logic [3:0]  in_bmask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_tag;
  logic        squash_valid;
  logic [3:0]  squash_mask;
  logic        resolve_valid;
  logic [3:0]  resolve_mask;

  mult_pipe dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_func       (in_func),
    .in_tag        (in_tag),
    .in_bmask      (in_bmask),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_tag       (out_tag),
    .squash_valid  (squash_valid),
    .squash_mask   (squash_mask),
    .resolve_valid (resolve_valid),
    .resolve_mask  (resolve_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    logic [3:0]  bm;
  } exp_t;

  exp_t        sbq[$];
  exp_t        keep[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  logic [31:0] cur_exp = '0;

  task automatic check(string name, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(mult_func_t f,
                                          logic [31:0] a,
                                          logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      M_MUL, M_MULH: p = sa * sb;
      M_MULHSU:      p = sa * ub;
      default:       p = ua * ub;
    endcase
    return (f == M_MUL) ? p[31:0] : p[63:32];
  endfunction

  // scoreboard: apply this cycle's handshake, squash, resolve, issue
  always @(negedge clock) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("spurious_out", {63'b0, out_valid}, 64'd0);
        end else begin
          e = sbq.pop_front();
          check("result", {32'b0, out_result}, {32'b0, e.res});
          check("tag", {58'b0, out_tag}, {58'b0, e.tag});
          n_out++;
        end
      end
      if (squash_valid) begin
        keep.delete();
        foreach (sbq[i])
          if ((sbq[i].bm & squash_mask) == 4'h0)
            keep.push_back(sbq[i]);
        sbq = keep;
      end
      if (resolve_valid)
        foreach (sbq[i]) sbq[i].bm = sbq[i].bm & ~resolve_mask;
      if (in_valid && in_ready &&
          !(squash_valid && |(in_bmask & squash_mask)))
        sbq.push_back('{cur_exp, in_tag,
          in_bmask & ~(resolve_valid ? resolve_mask : 4'h0)});
    end
  end

  task automatic drive(mult_func_t f, logic [31:0] a,
                       logic [31:0] b, logic [5:0] t,
                       logic [3:0] bm, logic [31:0] x);
    in_valid = 1'b1;
    in_func  = f;
    in_rs1   = a;
    in_rs2   = b;
    in_tag   = t;
    in_bmask = bm;
    cur_exp  = x;
  endtask

  task automatic issue(mult_func_t f, logic [31:0] a,
                       logic [31:0] b, logic [5:0] t,
                       logic [3:0] bm, logic [31:0] x);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    drive(f, a, b, t, bm, x);
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!acc) check("issue_timeout", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick(1);
      n++;
    end
    check("wait_out_valid", {63'b0, out_valid}, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    check("drain_empty", sbq.size(), 64'd0);
  endtask

  task automatic latency(logic [31:0] x);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check("latency_valid", {63'b0, out_valid}, {63'b0, i == 4});
    end
    check("latency_result", {32'b0, out_result}, {32'b0, x});
  endtask

  initial begin
    int n0;
    logic [31:0] a, b;
    reset = 1'b0;
    in_valid = 1'b0;
    in_rs1 = '0;
    in_rs2 = '0;
    in_func = M_MUL;
    in_tag = '0;
    in_bmask = '0;
    out_ready = 1'b1;
    squash_valid = 1'b0;
    squash_mask = '0;
    resolve_valid = 1'b0;
    resolve_mask = '0;

    tick(2);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_result", {32'b0, out_result}, 64'd0);
    check("rst_out_tag", {58'b0, out_tag}, 64'd0);
    reset = 1'b1;
    tick(1);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);

    drive(M_MUL, 32'd3, 32'd4, 6'h2A, 4'h0, 32'd12);
    tick(1);
    in_valid = 1'b0;
    latency(32'd12);
    check("latency_tag", {58'b0, out_tag}, 64'h2A);
    drain();

    issue(M_MUL, '1, '1, 6'h01, 4'h0, 32'h00000001);
    issue(M_MULH, '1, '1, 6'h02, 4'h0, 32'h00000000);
    issue(M_MULHU, '1, '1, 6'h03, 4'h0, 32'hFFFFFFFE);
    issue(M_MULHSU, '1, '1, 6'h04, 4'h0, 32'hFFFFFFFF);
    issue(M_MULH, 32'h80000000, 32'h80000000, 6'h05, 4'h0,
          32'h40000000);
    drain();

    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 10; k++) begin
        if (f == 2 && k == 0) begin
          out_ready = 1'b0;
          repeat (3) begin
            @(negedge clock);
            check("stall_in_ready", {63'b0, in_ready}, 64'd0);
            @(posedge clock);
            #1;
          end
          out_ready = 1'b1;
        end
        a = $urandom;
        b = $urandom;
        issue(mult_func_t'(f), a, b, 6'($urandom), 4'h0,
              ref_mul(mult_func_t'(f), a, b));
      end
    end
    drain();

    n0 = n_out;
    issue(M_MUL, 32'd5, 32'd6, 6'h11, 4'b0001, 32'd30);
    issue(M_MUL, 32'd7, 32'd8, 6'h12, 4'b0010, 32'd56);
    issue(M_MUL, 32'd9, 32'd10, 6'h13, 4'b0001, 32'd90);
    resolve_valid = 1'b1;
    resolve_mask = 4'b0010;
    tick(1);
    resolve_valid = 1'b0;
    squash_valid = 1'b1;
    squash_mask = 4'b0001;
    tick(1);
    squash_mask = 4'b0010;
    tick(1);
    squash_valid = 1'b0;
    tick(8);
    check("squash_completions", n_out - n0, 64'd1);
    drain();

    out_ready = 1'b0;
    issue(M_MUL, 32'd11, 32'd3, 6'h21, 4'b0100, 32'd33);
    issue(M_MUL, 32'd4, 32'd5, 6'h22, 4'b0000, 32'd20);
    wait_out();
    check("sq_head_tag", {58'b0, out_tag}, 64'h21);
    check("sq_stall_rdy", {63'b0, in_ready}, 64'd0);
    squash_valid = 1'b1;
    squash_mask = 4'b0100;
    #1;
    check("sq_comb_valid", {63'b0, out_valid}, 64'd0);
    tick(1);
    squash_valid = 1'b0;
    check("sq_reg_valid", {63'b0, out_valid}, 64'd0);
    wait_out();
    check("sq_next_tag", {58'b0, out_tag}, 64'h22);
    check("sq_next_res", {32'b0, out_result}, 64'd20);
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    issue(M_MULHU, 32'd100, 32'd7, 6'h31, 4'h0, 32'd0);
    issue(M_MUL, 32'd100, 32'd7, 6'h32, 4'h0, 32'd700);
    issue(M_MUL, 32'd9, 32'd9, 6'h33, 4'h0, 32'd81);
    issue(M_MUL, 32'd8, 32'd8, 6'h34, 4'h0, 32'd64);
    wait_out();
    reset = 1'b0;
    #1;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_out_tag", {58'b0, out_tag}, 64'd0);
    sbq.delete();
    tick(2);
    reset = 1'b1;
    out_ready = 1'b1;
    tick(1);
    check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    check("midrst_no_out", {63'b0, out_valid}, 64'd0);
    drive(M_MUL, 32'd2, 32'd15, 6'h3F, 4'h0, 32'd30);
    tick(1);
    in_valid = 1'b0;
    latency(32'd30);
    check("midrst_tag", {58'b0, out_tag}, 64'h3F);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
Parametrised, fully pipelined RV32M multiplier functional unit. It is the successor of the current multi-cycle `mult` FU.
- Accepts one issue packet per cycle and produces results in order after NUM_STAGES cycles.
- Supports back-pressure from the CDB/complete stage.
- Supports branch-mask squash and branch-resolve mask clearing for speculative execution.
- Sits between the issue stage (RS) and the complete stage, alongside the ALU FUs.

Parameters:
XLEN, 32, operand/result width; must be divisible by NUM_STAGES
NUM_STAGES, 4, pipeline depth; each stage consumes XLEN/NUM_STAGES bits of the rs2 operand
TAG_W, 6, width of the destination physical-register tag carried with each op
BMASK_W, 4, branch-mask width (one bit per in-flight branch)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  issue packet valid
in_ready  out  1  unit can accept this cycle
in_rs1  in  XLEN  operand 1
in_rs2  in  XLEN  operand 2
in_func  in  2  MULT_FUNC: M_MUL, M_MULH, M_MULHSU, M_MULHU
in_tag  in  TAG_W  destination tag
in_bmask  in  BMASK_W  branch dependency mask
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result (deasserted = stall)
out_result  out  XLEN  selected product half
out_tag  out  TAG_W  tag of out_result
squash_valid  in  1  branch mispredict
squash_mask  in  BMASK_W  one-hot bit of the mispredicted branch
resolve_valid  in  1  branch resolved correctly
resolve_mask  in  BMASK_W  one-hot bit to clear

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits = 0; out_valid = 0; out_result = 0; out_tag = 0; bmasks = 0. in_ready = 1 one cycle after reset releases.
- Global advance: advance = !out_valid_reg || out_ready. The pipeline moves one stage per cycle only when advance=1; otherwise every stage holds.
- Input handshake: in_ready = advance. An op is accepted when in_valid && in_ready.
- Latency: an op accepted at edge N asserts out_valid after edge N+NUM_STAGES with no stall. Throughput is one op per cycle.
- Operand extension to 2*XLEN:
  - MUL and MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both operands unsigned.
- Partial products: stage k adds ext_rs1 * rs2 chunk k, shifted by k*(XLEN/NUM_STAGES).
  - The top chunk of a signed rs2 carries negative weight.
  - The accumulator is 2*XLEN bits and wraps modulo 2^(2*XLEN).
- Result selection: M_MUL takes product[XLEN-1:0]; all other functions take product[2*XLEN-1:XLEN].
- Each stage carries: valid, func, tag, bmask, partial sum, the remaining rs2 bits, and ext rs1.
- Squash: on squash_valid, every stage (including the output register) whose bmask & squash_mask != 0 is invalidated at the next edge.
  - out_valid is masked combinationally in the squash cycle, so a squashed result is never handshaken.
  - An input op carrying the squashed bit is not accepted: in_ready is unaffected, but the op enters as invalid.
- Resolve: on resolve_valid, resolve_mask is cleared from every stage's bmask and from the incoming in_bmask.
- Squash and resolve on the same cycle with different bits: both are applied. The same bit is never asserted on both (upstream guarantee); if it is, squash wins.
- A squash during a stall still invalidates the matching entries. The stall remains governed by the new out_valid.
- Reset mid-operation: all in-flight ops are discarded immediately and no output is produced.
- in_func values outside the enum produce result 0 (unreachable in the decoder).

Decomposition:
- sys_defs.svh: the MULT_FUNC enum (already present), BMASK_W, TAG_W, and a MULT_STAGE_PACKET struct (valid, func, tag, bmask, sum, rs1, rs2 remainder).
- One sub-module, mult_stage: combinational partial-product add for one chunk plus the registered stage packet with hold/squash/resolve logic. It is instantiated NUM_STAGES times via generate.

Test Plan:
- Default parameters, MUL 3*4 accepted at cycle 0, out_ready=1 -> out_valid exactly 4 cycles later, out_result=12, tag preserved.
- Func sweep with rs1=rs2=0xFFFFFFFF:
  - MUL -> 0x00000001
  - MULH -> 0x00000000
  - MULHU -> 0xFFFFFFFE
  - MULHSU -> 0xFFFFFFFF
  - Plus MULH 0x80000000*0x80000000 -> 0x40000000.
- Back-to-back 10 random ops per func with out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during the stall, no op lost or duplicated, in-order results matching the reference model.
- Three ops with bmask 0001, 0010, 0001 in flight, squash_mask=0001 -> only the 0010 op completes; resolve_mask=0010 beforehand -> its bmask reads 0000.
- Squash hitting the entry at the output while out_ready=0 -> out_valid low in that same cycle, next queued op emerges after the stall releases.
- Assert reset low while 4 ops are in flight -> out_valid=0 immediately; after release, a fresh MUL 2*15 -> 30 with normal latency.
